strait_test_sequencer: RTL and testbench
========================================

STRAIT_TEST_SEQUENCER -- requirements
Module: strait_test_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent waiting for test_done in one phase.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles between the MBIST result and the LBIST START pulse (minimum 1).
REQ-003 SHALL have parameter ABORT_ON_MBIST_FAIL, default 0: when 1, LBIST is skipped after an MBIST failure.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 run_req  input  1  request a full self-test run; level-sampled, acted on only in IDLE.
REQ-007 test_done  input  1  BIST-complete level from the STRAIT hybrid BIST.
REQ-008 MBIST_FAIL  input  1  MBIST result; valid while test_done is high in the MBIST phase.
REQ-009 TD_error_flag  input  1  LBIST result; valid while test_done is high in the LBIST phase.
REQ-010 START  output  1  one-cycle BIST start pulse to STRAIT.
REQ-011 test_mode  output  1  high throughout a run.
REQ-012 BIST_mode  output  1  0 = MBIST, 1 = LBIST.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 seq_done  output  1  one-cycle pulse at the end of a run.
REQ-015 mbist_fail, lbist_fail, timeout_flag, timeout_phase  output  1 each  run status; timeout_phase is 0 = MBIST, 1 = LBIST.
REQ-016 pass  output  1  equals ~mbist_fail & ~lbist_fail & ~timeout_flag & run_valid, where run_valid is an internal flag set at the first seq_done.

Function
REQ-017 SHALL implement states IDLE, MB_START, MB_WAIT, GAP, LB_START, LB_WAIT, DONE; all outputs SHALL be registered.
REQ-018 IDLE: when run_req is sampled high -> MB_START; the status outputs SHALL be cleared on this transition.
REQ-019 MB_START lasts one cycle with START=1, BIST_mode=0 -> MB_WAIT.
REQ-020 LB_START lasts one cycle with START=1, BIST_mode=1 -> LB_WAIT.
REQ-021 START SHALL be high only in MB_START and LB_START.
REQ-022 test_mode SHALL be 1 in MB_START through LB_WAIT, and 0 in IDLE and DONE.
REQ-023 BIST_mode SHALL be 1 in LB_START and LB_WAIT, and 0 otherwise.
REQ-024 WAIT states, stale-level guard: test_done is accepted only after it has been sampled low at least once in the current WAIT state. The armed flag clears on WAIT entry.
REQ-025 MB_WAIT accept: mbist_fail <= MBIST_FAIL -> GAP; -> DONE instead if ABORT_ON_MBIST_FAIL=1 and MBIST_FAIL=1.
REQ-026 LB_WAIT accept: lbist_fail <= TD_error_flag -> DONE.
REQ-027 The timeout counter SHALL clear on WAIT entry and increment each WAIT cycle. When TIMEOUT_CYCLES cycles elapse without an accept: timeout_flag <= 1, timeout_phase <= phase, -> DONE.
REQ-028 If an accept and the timeout occur in the same cycle, the accept SHALL win and timeout_flag SHALL stay 0.
REQ-029 GAP SHALL count exactly GAP_CYCLES cycles -> LB_START.
REQ-030 DONE lasts one cycle with seq_done=1 -> IDLE; the status outputs SHALL hold until the next accepted run_req.
REQ-031 run_req while busy SHALL be ignored (not queued).
REQ-032 Counter widths SHALL be $clog2(TIMEOUT_CYCLES+1) and $clog2(GAP_CYCLES+1); the counters SHALL saturate and never wrap.
REQ-033 Latency: run_req sampled at edge N -> START high for the cycle after edge N+1. MBIST accept at edge M -> LBIST START high after edge M+GAP_CYCLES+1.

Reset
REQ-034 rst_n low at a rising edge SHALL force state IDLE and set all outputs to 0, including run_valid; this applies mid-run.
REQ-035 After reset release no START SHALL be issued until a new run_req is sampled.

Verification (TIMEOUT_CYCLES=16, GAP_CYCLES=2)
REQ-036 Clean run: run_req pulse; model raises test_done 5 cycles after each START with both fail inputs 0 -> two START pulses separated by GAP timing; seq_done once; pass=1; all fail/timeout flags 0.
REQ-037 MBIST fail: MBIST_FAIL=1 at accept. With ABORT_ON_MBIST_FAIL=0 -> LBIST still runs, mbist_fail=1, pass=0. With ABORT_ON_MBIST_FAIL=1 -> no second START and seq_done one cycle after the accept.
REQ-038 Timeout: test_done never rises in LB_WAIT -> timeout_flag=1, timeout_phase=1, seq_done 16 cycles after LB_WAIT entry, test_mode=0 afterwards.
REQ-039 Stale done: test_done held high from the MBIST phase into LB_WAIT, then dropped and raised again -> lbist_fail latched only from the second rise.
REQ-040 Reset mid-run: rst_n=0 during MB_WAIT -> next edge has START=0, test_mode=0, busy=0, all status 0; a run_req issued during busy is ignored.
REQ-041 Coincidence: test_done rises on the 16th LB_WAIT cycle -> accepted, timeout_flag=0.

Source files
------------

// File: rtl/strait_test_sequencer.sv
// strait_test_sequencer: runs MBIST then LBIST on the STRAIT hybrid BIST and reports run status.
module strait_test_sequencer #(
  parameter int TIMEOUT_CYCLES      = 4096,
  parameter int GAP_CYCLES          = 2,
  parameter bit ABORT_ON_MBIST_FAIL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_req,
  input  logic test_done,
  input  logic MBIST_FAIL,
  input  logic TD_error_flag,
  output logic START,
  output logic test_mode,
  output logic BIST_mode,
  output logic busy,
  output logic seq_done,
  output logic mbist_fail,
  output logic lbist_fail,
  output logic timeout_flag,
  output logic timeout_phase,
  output logic pass
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] G_MAX  = GW'(GAP_CYCLES);
  typedef enum logic [2:0] {IDLE, MB_START, MB_WAIT, GAP, LB_START, LB_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic armed, run_valid, wait_st, accept, expire;
  logic mf_n, lf_n, tf_n, tp_n;
  // tcnt holds the WAIT cycles already spent, so the current cycle is tcnt+1
  always_comb begin
    wait_st = state == MB_WAIT || state == LB_WAIT;
    accept  = wait_st & armed & test_done;
    expire  = wait_st & (tcnt == T_LAST);
    state_n = state;
    mf_n    = mbist_fail;
    lf_n    = lbist_fail;
    tf_n    = timeout_flag;
    tp_n    = timeout_phase;
    case (state)
      IDLE: if (run_req) begin
        state_n = MB_START;
        {mf_n, lf_n, tf_n, tp_n} = '0;
      end
      MB_START: state_n = MB_WAIT;
      MB_WAIT: if (accept) begin
        mf_n    = MBIST_FAIL;
        state_n = (ABORT_ON_MBIST_FAIL && MBIST_FAIL) ? DONE : GAP;
      end else if (expire) begin
        {tf_n, tp_n} = 2'b10;
        state_n      = DONE;
      end
      GAP: state_n = (gcnt == G_LAST) ? LB_START : GAP;
      LB_START: state_n = LB_WAIT;
      LB_WAIT: if (accept) begin
        lf_n    = TD_error_flag;
        state_n = DONE;
      end else if (expire) begin
        {tf_n, tp_n} = 2'b11;
        state_n      = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // control outputs are registered decodes of the state, one cycle behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      gcnt      <= '0;
      armed     <= 1'b0;
      run_valid <= 1'b0;
      {START, test_mode, BIST_mode, busy, seq_done} <= '0;
      {mbist_fail, lbist_fail, timeout_flag, timeout_phase, pass} <= '0;
    end else begin
      state         <= state_n;
      tcnt          <= wait_st ? ((tcnt == T_MAX) ? tcnt : tcnt + TW'(1)) : '0;
      gcnt          <= (state == GAP) ? ((gcnt == G_MAX) ? gcnt : gcnt + GW'(1)) : '0;
      armed         <= wait_st & (armed | ~test_done);
      run_valid     <= run_valid | (state == DONE);
      START         <= state == MB_START || state == LB_START;
      test_mode     <= state inside {MB_START, MB_WAIT, GAP, LB_START, LB_WAIT};
      BIST_mode     <= state == LB_START || state == LB_WAIT;
      busy          <= state != IDLE;
      seq_done      <= state == DONE;
      mbist_fail    <= mf_n;
      lbist_fail    <= lf_n;
      timeout_flag  <= tf_n;
      timeout_phase <= tp_n;
      pass          <= ~mf_n & ~lf_n & ~tf_n & (run_valid | (state == DONE));
    end
  end
endmodule

// File: tb/tb_strait_test_sequencer.sv
// tb_strait_test_sequencer: directed and random checks of two sequencers (abort off/on) against a timestamp model.
module tb_strait_test_sequencer;
  localparam int TO  = 16;
  localparam int GAP = 2;
  localparam int O_START = 9, O_TM = 8, O_BM = 7, O_BUSY = 6, O_SD = 5;
  localparam int O_MF = 4, O_LF = 3, O_TF = 2, O_TP = 1, O_PASS = 0;
  localparam int P_IDLE = 0, P_MBS = 1, P_MBW = 2, P_GAP = 3, P_LBS = 4, P_LBW = 5, P_DONE = 6;
  bit clk;
  logic rst_n, run_req, test_done, MBIST_FAIL, TD_error_flag;
  wire [9:0] act0, act1;
  int cmp, mis, cyc;
  int ph[2], t0[2];
  bit arm[2], mf[2], lf[2], tf[2], tp[2], rv[2];
  logic [9:0] exp_o[2];
  always #5 clk = ~clk;
  strait_test_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .ABORT_ON_MBIST_FAIL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .test_done(test_done), .MBIST_FAIL(MBIST_FAIL),
    .TD_error_flag(TD_error_flag), .START(act0[O_START]), .test_mode(act0[O_TM]), .BIST_mode(act0[O_BM]),
    .busy(act0[O_BUSY]), .seq_done(act0[O_SD]), .mbist_fail(act0[O_MF]), .lbist_fail(act0[O_LF]),
    .timeout_flag(act0[O_TF]), .timeout_phase(act0[O_TP]), .pass(act0[O_PASS]));
  strait_test_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .ABORT_ON_MBIST_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .test_done(test_done), .MBIST_FAIL(MBIST_FAIL),
    .TD_error_flag(TD_error_flag), .START(act1[O_START]), .test_mode(act1[O_TM]), .BIST_mode(act1[O_BM]),
    .busy(act1[O_BUSY]), .seq_done(act1[O_SD]), .mbist_fail(act1[O_MF]), .lbist_fail(act1[O_LF]),
    .timeout_flag(act1[O_TF]), .timeout_phase(act1[O_TP]), .pass(act1[O_PASS]));
  task automatic go(input int i, input int p);
    ph[i] = p;
    t0[i] = cyc;
  endtask
  // Model: phase plus the edge it was entered on; outputs show the phase held before each edge.
  task automatic step(input int i);
    int n;
    bit wt, acc;
    logic [4:0] lag;
    if (!rst_n) begin
      ph[i] = P_IDLE; arm[i] = 0; mf[i] = 0; lf[i] = 0; tf[i] = 0; tp[i] = 0; rv[i] = 0;
      exp_o[i] = '0;
      return;
    end
    n   = cyc - t0[i];
    wt  = ph[i] == P_MBW || ph[i] == P_LBW;
    acc = wt && arm[i] && test_done === 1'b1;
    lag = {ph[i] == P_MBS || ph[i] == P_LBS, ph[i] >= P_MBS && ph[i] <= P_LBW,
           ph[i] == P_LBS || ph[i] == P_LBW, ph[i] != P_IDLE, ph[i] == P_DONE};
    if (ph[i] == P_DONE) rv[i] = 1;
    case (ph[i])
      P_IDLE: if (run_req) begin
        mf[i] = 0; lf[i] = 0; tf[i] = 0; tp[i] = 0;
        go(i, P_MBS);
      end
      P_MBS: go(i, P_MBW);
      P_LBS: go(i, P_LBW);
      P_GAP: if (n >= GAP) go(i, P_LBS);
      P_DONE: go(i, P_IDLE);
      default: if (acc) begin
        if (ph[i] == P_MBW) begin
          mf[i] = MBIST_FAIL;
          go(i, (i == 1 && MBIST_FAIL) ? P_DONE : P_GAP);
        end else begin
          lf[i] = TD_error_flag;
          go(i, P_DONE);
        end
      end else if (n >= TO) begin
        tf[i] = 1;
        tp[i] = ph[i] == P_LBW;
        go(i, P_DONE);
      end
    endcase
    arm[i] = (wt && t0[i] != cyc) ? (arm[i] | !test_done) : 1'b0;
    exp_o[i] = {lag, mf[i], lf[i], tf[i], tp[i], !mf[i] && !lf[i] && !tf[i] && rv[i]};
  endtask
  always @(posedge clk) begin
    cyc++;
    step(0);
    step(1);
  end
  always @(negedge clk) begin
    cmp += 2;
    if (act0 !== exp_o[0]) begin
      mis++;
      $display("FAIL u0_outputs @%0d: got %b want %b", cyc, act0, exp_o[0]);
    end
    if (act1 !== exp_o[1]) begin
      mis++;
      $display("FAIL u1_outputs @%0d: got %b want %b", cyc, act1, exp_o[1]);
    end
  end
  task automatic chk(input string nm, input int got, input int want);
    cmp++;
    if (got != want) begin
      mis++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic wait_sig(input int b, output int c);
    c = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (act0[b] === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      cmp++;
      mis++;
      $display("FAIL wait_bit%0d: got timeout want event", b);
    end
  endtask
  task automatic kick(output int n);
    @(negedge clk);
    run_req = 1;
    n = cyc + 1;
    @(negedge clk);
    run_req = 0;
  endtask
  task automatic run_std(input bit mbf, input bit lbf);
    int n, s1, s2, d, cnt;
    kick(n);
    wait_sig(O_START, s1);
    chk("start_latency", s1 - n, 1);
    repeat (5) @(negedge clk);
    test_done  = 1;
    MBIST_FAIL = mbf;
    repeat (2) @(negedge clk);
    chk("abort_seq_done", act1[O_SD], mbf);
    run_req = !mbf;
    @(negedge clk);
    run_req = 0;
    wait_sig(O_START, s2);
    test_done = 0;
    chk("gap_spacing", s2 - s1, 9);
    chk("u1_lbist_start", act1[O_START], !mbf);
    repeat (5) @(negedge clk);
    test_done     = 1;
    TD_error_flag = lbf;
    wait_sig(O_SD, d);
    chk("done_latency", d - s2, 7);
    chk("mbist_fail", act0[O_MF], mbf);
    chk("lbist_fail", act0[O_LF], lbf);
    chk("pass", act0[O_PASS], !mbf && !lbf);
    chk("timeout_flag", act0[O_TF], 0);
    test_done = 0; MBIST_FAIL = 0; TD_error_flag = 0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      cnt += act0[O_START];
    end
    chk("no_queued_run", cnt, 0);
  endtask
  task automatic run_to(input bit coincide);
    int n, s1, s2, d;
    kick(n);
    wait_sig(O_START, s1);
    repeat (5) @(negedge clk);
    test_done = 1;
    wait_sig(O_START, s2);
    test_done     = 0;
    TD_error_flag = 1;
    if (coincide) begin
      repeat (15) @(negedge clk);
      test_done = 1;
    end
    wait_sig(O_SD, d);
    chk("timeout_done_latency", d - s2, 17);
    chk("timeout_flag_lb", act0[O_TF], !coincide);
    chk("timeout_phase_lb", act0[O_TP], !coincide);
    chk("lbist_fail_lb", act0[O_LF], coincide);
    chk("test_mode_after", act0[O_TM], 0);
    test_done = 0; TD_error_flag = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic run_stale();
    int n, s1, s2, d;
    kick(n);
    wait_sig(O_START, s1);
    repeat (5) @(negedge clk);
    test_done = 1;
    wait_sig(O_START, s2);
    TD_error_flag = 1;
    repeat (4) @(negedge clk);
    test_done = 0; TD_error_flag = 0;
    repeat (2) @(negedge clk);
    test_done = 1;
    wait_sig(O_SD, d);
    chk("stale_done_latency", d - s2, 8);
    chk("stale_lbist_fail", act0[O_LF], 0);
    test_done = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic run_reset();
    int n, s1, cnt;
    kick(n);
    wait_sig(O_START, s1);
    repeat (2) @(negedge clk);
    rst_n   = 0;
    run_req = 1;
    @(negedge clk);
    chk("midrun_reset_u0", act0, 0);
    chk("midrun_reset_u1", act1, 0);
    rst_n   = 1;
    run_req = 0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += act0[O_START] + act1[O_START];
    end
    chk("no_start_after_reset", cnt, 0);
  endtask
  initial begin
    int hold;
    rst_n = 0; run_req = 0; test_done = 0; MBIST_FAIL = 0; TD_error_flag = 0;
    repeat (3) @(negedge clk);
    chk("reset_state_u0", act0, 0);
    chk("reset_state_u1", act1, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run_std(0, 0);
    run_std(1, 0);
    run_std(0, 1);
    run_to(0);
    run_to(1);
    run_stale();
    run_reset();
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (hold == 0) begin
        test_done = ~test_done;
        hold = ($urandom % 4 == 0) ? $urandom_range(10, 24) : $urandom_range(1, 6);
      end
      hold--;
      run_req       = $urandom % 12 == 0;
      MBIST_FAIL    = $urandom % 2;
      TD_error_flag = $urandom % 2;
      rst_n         = $urandom % 500 != 0;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
